// File: rtl/approx_mult_seq.sv
// approx_mult_seq
// ---------------------------------------------------------------------------
// Iterative WIDTH x WIDTH unsigned approximate multiplier. The product is
// assembled from four (WIDTH/2)x(WIDTH/2) quadrant sub-products computed on
// one shared sub-multiplier, one quadrant per clock, in the order
// LL, LH, HL, HH. Each quadrant can be exact or truncated at run time.
// Quadrants are accumulated by exact addition or, optionally, by bitwise OR.
//
// Optional feature macro: APPROX_OR_ACC_EN
//   defined     -> acc_or is latched at accept; 1 selects OR accumulation
//   not defined -> acc_or is ignored, accumulation is always add, and no
//                  OR datapath is built
//
// Parameters
//   WIDTH  operand width (even, >= 4)
//   TRUNC  low bits cleared in an approximate sub-product (0..WIDTH-1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand request
//   in_ready   block accepts operands (high only in IDLE)
//   a, b       unsigned operands
//   qmode      per-quadrant approx enable: [0] LL, [1] LH, [2] HL, [3] HH
//   acc_or     1 = OR accumulation (only with APPROX_OR_ACC_EN)
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   result     2*WIDTH-bit product (meaningful while out_valid = 1)
// ---------------------------------------------------------------------------
module approx_mult_seq #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           qmode,
    input  logic                 acc_or,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int H       = WIDTH / 2;
    localparam int PW      = 2 * H;            // sub-product width
    localparam int RW      = 2 * WIDTH;        // result width
    localparam int TRUNC_C = (TRUNC > PW) ? PW : TRUNC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [1:0]        cnt_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [3:0]        qmode_reg;
    logic [RW-1:0]     acc_reg;

    // ------------------------------------------------------------------
    // Shared quadrant sub-multiplier.
    // cnt[1] selects the a half (HL, HH use a_hi), cnt[0] selects the
    // b half (LH, HH use b_hi), which matches the LL, LH, HL, HH order.
    // ------------------------------------------------------------------
    logic [H-1:0]      x_sel;
    logic [H-1:0]      y_sel;
    logic [PW-1:0]     p_full;
    logic [PW-1:0]     p_keep;
    logic [PW-1:0]     trunc_mask;
    logic [RW-1:0]     p_ext;
    logic [RW-1:0]     term;
    logic [RW-1:0]     acc_step;

    assign x_sel  = cnt_reg[1] ? a_reg[WIDTH-1:H] : a_reg[H-1:0];
    assign y_sel  = cnt_reg[0] ? b_reg[WIDTH-1:H] : b_reg[H-1:0];
    assign p_full = {{(PW-H){1'b0}}, x_sel} * {{(PW-H){1'b0}}, y_sel};

    // Constant mask that clears the TRUNC low bits of an approximate term.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_trunc_mask
            assign trunc_mask[gi] = (gi >= TRUNC_C) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign p_keep = qmode_reg[cnt_reg] ? (p_full & trunc_mask) : p_full;
    assign p_ext  = {{(RW-PW){1'b0}}, p_keep};

    always_comb begin
        term = p_ext;
        case (cnt_reg)
            2'd0:    term = p_ext;
            2'd1:    term = p_ext << H;
            2'd2:    term = p_ext << H;
            default: term = p_ext << PW;
        endcase
    end

`ifdef APPROX_OR_ACC_EN
    logic acc_or_reg;

    assign acc_step = acc_or_reg ? (acc_reg | term) : (acc_reg + term);
`else
    // acc_or has no effect in this build; tie it off so it is not flagged.
    logic unused_acc_or;

    assign unused_acc_or = acc_or;
    assign acc_step      = acc_reg + term;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_valid)          state_next = S_CALC;
            S_CALC: if (cnt_reg == 2'd3)   state_next = S_DONE;
            S_DONE: if (out_ready)         state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from state and registers only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_reg == S_IDLE);
        out_valid = (state_reg == S_DONE);
        result    = acc_reg;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= 2'd0;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            qmode_reg  <= 4'd0;
`ifdef APPROX_OR_ACC_EN
            acc_or_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        qmode_reg  <= qmode;
`ifdef APPROX_OR_ACC_EN
                        acc_or_reg <= acc_or;
`endif
                        acc_reg    <= '0;
                        cnt_reg    <= 2'd0;
                    end
                end
                S_CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 2'd1;
                end
                default: begin
                    // DONE: hold acc so result stays stable under backpressure
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Testbench for approx_mult_seq (WIDTH=8, TRUNC=2).
// Expected products come from a quadrant-arithmetic reference model.
module tb_approx_mult_seq;

    localparam int WIDTH = 8;
    localparam int TRUNC = 2;

`ifdef APPROX_OR_ACC_EN
    localparam bit OR_EN = 1'b1;
`else
    localparam bit OR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  qmode;
    logic        acc_or;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks;
    int failures;

    approx_mult_seq #(.WIDTH(WIDTH), .TRUNC(TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .qmode     (qmode),
        .acc_or    (acc_or),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum (or OR) of the four shifted quadrant products.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [3:0] mq, input logic mor);
        int unsigned acc;
        int unsigned x;
        int unsigned y;
        int unsigned p;
        int unsigned sh;
        acc = 0;
        for (int q = 0; q < 4; q++) begin
            x = (q >= 2) ? (ma / 16) : (ma % 16);
            y = (q % 2 == 1) ? (mb / 16) : (mb % 16);
            p = x * y;
            if (mq[q]) p = p - (p % (1 << TRUNC));
            sh = (q == 0) ? 0 : ((q == 3) ? 8 : 4);
            if (mor && OR_EN) acc = acc | (p << sh);
            else              acc = (acc + (p << sh)) % 65536;
        end
        return acc[15:0];
    endfunction

    // One full transaction; starts and ends at a negedge. Operand inputs are
    // scrambled after accept to confirm they are latched.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] tq,
                         input logic to, input int gap,
                         output logic [15:0] res_first, output logic [15:0] res_late,
                         output int lat, output bit timeout);
        int n;
        timeout = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout = 1'b1;
        a = ta; b = tbv; qmode = tq; acc_or = to; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); qmode = 4'($urandom); acc_or = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        res_first = result;
        repeat (gap) @(negedge clk);
        res_late = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, required 1 0 0000",
                     in_ready, out_valid, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
    endtask

    task automatic test_exact_max();
        logic [15:0] r1, r2;
        int lat;
        bit to;
        do_op(8'hFF, 8'hFF, 4'b0000, 1'b0, 0, r1, r2, lat, to);
        $display("exact_max: a=ff b=ff result=%h latency=%0d", r1, lat);
        checks++;
        if (to || lat != 4) begin
            failures++;
            $display("FAIL exact_max_latency: got %0d timeout=%0d, required 4", lat, to);
        end
        checks++;
        if (r1 !== 16'hFE01) begin
            failures++;
            $display("FAIL exact_max_result: got %h, required fe01", r1);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_trunc_ll();
        logic [15:0] r1, r2;
        int lat;
        bit to;
        do_op(8'h0F, 8'h0F, 4'b0001, 1'b0, 0, r1, r2, lat, to);
        $display("trunc_ll: a=0f b=0f qmode=0001 result=%h", r1);
        checks++;
        if (to || r1 !== 16'h00E0) begin
            failures++;
            $display("FAIL trunc_ll: got %h timeout=%0d, required 00e0", r1, to);
        end
    endtask

    task automatic test_or_mode();
        logic [15:0] r1, r2;
        logic [15:0] exp_v;
        int lat;
        bit to;
        exp_v = OR_EN ? 16'hEFF1 : 16'hFE01;
        do_op(8'hFF, 8'hFF, 4'b0000, 1'b1, 0, r1, r2, lat, to);
        $display("or_mode: a=ff b=ff acc_or=1 result=%h", r1);
        checks++;
        if (to || r1 !== exp_v) begin
            failures++;
            $display("FAIL or_mode: got %h timeout=%0d, required %h", r1, to, exp_v);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r1, r2, held;
        int lat;
        int bad;
        int n;
        bit to;
        a = 8'h12; b = 8'h34; qmode = 4'b0000; acc_or = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = result;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            a = 8'h01; b = 8'h01; in_valid = 1'b1;
            @(negedge clk);
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        $display("backpressure: held=%h bad_cycles=%0d", held, bad);
        checks++;
        if (n >= 20 || held !== 16'h03A8 || bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: result=%h bad_cycles=%0d, required 03a8 and 0", held, bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        do_op(8'h07, 8'h09, 4'b0000, 1'b0, 0, r1, r2, lat, to);
        $display("post_backpressure: a=07 b=09 result=%h", r1);
        checks++;
        if (to || r1 !== 16'd63) begin
            failures++;
            $display("FAIL post_backpressure: got %h, required %h", r1, 16'd63);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r1, r2;
        int lat;
        int seen;
        bit to;
        a = 8'h55; b = 8'h66; qmode = 4'b0000; acc_or = 1'b0; in_valid = 1'b1;
        @(negedge clk);               // accepted
        in_valid = 1'b0;
        @(negedge clk);               // second CALC cycle
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b result=%h, required 1 0 0000",
                     in_ready, out_valid, result);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        $display("reset_mid: stray out_valid cycles=%0d", seen);
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_result: out_valid cycles=%0d, required 0", seen);
        end
        do_op(8'd3, 8'd5, 4'b0000, 1'b0, 0, r1, r2, lat, to);
        $display("reset_mid_fresh: a=3 b=5 result=%0d", r1);
        checks++;
        if (to || r1 !== 16'd15) begin
            failures++;
            $display("FAIL reset_mid_fresh: got %0d, required 15", r1);
        end
    endtask

    task automatic test_random(input int count, input bit approx);
        logic [7:0]  ra, rb;
        logic [3:0]  rq;
        logic        ro;
        logic [15:0] r1, r2, exp_v;
        int lat;
        bit to;
        for (int i = 0; i < count; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rq = approx ? 4'($urandom) : 4'b0000;
            ro = approx ? 1'($urandom) : 1'b0;
            exp_v = model(ra, rb, rq, ro);
            do_op(ra, rb, rq, ro, int'($urandom_range(0, 3)), r1, r2, lat, to);
            $display("random%s %0d: a=%h b=%h q=%b or=%b result=%h exp=%h",
                     approx ? "_approx" : "_exact", i, ra, rb, rq, ro, r1, exp_v);
            checks++;
            if (to || lat != 4 || r1 !== exp_v || r2 !== exp_v || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d: result=%h/%h lat=%0d out_valid_after=%b, required %h lat 4 out_valid 0",
                         i, r1, r2, lat, out_valid, exp_v);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        qmode     = 4'b0000;
        acc_or    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_exact_max();
        test_trunc_ll();
        test_or_mode();
        test_backpressure();
        test_reset_mid();
        test_random(1000, 1'b0);
        test_random(200, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
